// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: issues FIFO reads, absorbs the 1-cycle read latency
// in a 2-entry skid buffer and presents the words as a valid/ready stream.
module fifo_rd_stream #(
  parameter int DATA_LEN = 8,
  parameter int CNT_LEN  = 16
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic                drain_en,
  input  logic                rd_empty,
  input  logic [DATA_LEN-1:0] rd_data,
  output logic                rd_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_data,
  output logic [CNT_LEN-1:0]  out_count,
  output logic                busy
);

  logic [1:0]          occ_r;
  logic                inflight_r;
  logic                head_r;
  logic                tail_r;
  logic [DATA_LEN-1:0] mem_r [2];
  logic [CNT_LEN-1:0]  count_r;

  logic                pop_s;
  logic [2:0]          committed_s;
  logic [2:0]          limit_s;

  assign pop_s       = out_valid && out_ready;
  // Words already owed to the buffer (stored + in flight) must stay below 2
  // after this cycle's pop; pop is added on the right to avoid underflow.
  assign committed_s = {1'b0, occ_r} + {2'b00, inflight_r};
  assign limit_s     = 3'd2 + {2'b00, pop_s};
  assign rd_en       = !rd_rst && drain_en && !rd_empty && (committed_s < limit_s);

  assign out_valid   = (occ_r != 2'd0);
  assign out_data    = mem_r[head_r];
  assign out_count   = count_r;
  assign busy        = (occ_r != 2'd0) || inflight_r || rd_en;

  // Skid buffer occupancy, pointers, storage and the read-in-flight flag.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      occ_r      <= 2'd0;
      inflight_r <= 1'b0;
      head_r     <= 1'b0;
      tail_r     <= 1'b0;
      mem_r[0]   <= {DATA_LEN{1'b0}};
      mem_r[1]   <= {DATA_LEN{1'b0}};
    end else begin
      inflight_r <= rd_en;
      occ_r      <= occ_r + {1'b0, inflight_r} - {1'b0, pop_s};
      if (inflight_r) begin
        mem_r[tail_r] <= rd_data;
        tail_r        <= ~tail_r;
      end
      if (pop_s) begin
        head_r <= ~head_r;
      end
    end
  end

  // Delivered-word counter, wraps naturally at 2^CNT_LEN.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      count_r <= {CNT_LEN{1'b0}};
    end else if (pop_s) begin
      count_r <= count_r + {{(CNT_LEN-1){1'b0}}, 1'b1};
    end
  end

  fifo_rd_stream_chk u_chk (
    .clk      (rd_clk),
    .rst      (rd_rst),
    .occ      (occ_r),
    .inflight (inflight_r)
  );

endmodule

// Invariant monitor: the buffer can never be over-committed.
module fifo_rd_stream_chk (
  input logic       clk,
  input logic       rst,
  input logic [1:0] occ,
  input logic       inflight
);

  a_no_overcommit: assert property (@(posedge clk) disable iff (rst)
    (({1'b0, occ} + {2'b00, inflight}) <= 3'd2));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized bench for fifo_rd_stream: a queue-based FIFO model plus a
// transaction-level scoreboard that predicts stream timing and contents.
module tb_fifo_rd_stream;

  logic        rd_clk = 1'b0;
  logic        rd_rst;
  logic        drain_en;
  logic        rd_empty;
  logic [7:0]  rd_data = 8'h00;
  logic        rd_en, out_valid, out_ready, busy;
  logic [7:0]  out_data;
  logic [15:0] out_count;
  logic        rd_en_w4, out_valid_w4, busy_w4;
  logic [7:0]  out_data_w4;
  logic [3:0]  out_count_w4;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int delivered = 0;
  int issued = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         iss_q[$];

  fifo_rd_stream #(.DATA_LEN(8), .CNT_LEN(16)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .drain_en(drain_en), .rd_empty(rd_empty),
    .rd_data(rd_data), .rd_en(rd_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .busy(busy)
  );

  fifo_rd_stream #(.DATA_LEN(8), .CNT_LEN(4)) dut_w4 (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .drain_en(drain_en), .rd_empty(rd_empty),
    .rd_data(rd_data), .rd_en(rd_en_w4), .out_valid(out_valid_w4), .out_ready(out_ready),
    .out_data(out_data_w4), .out_count(out_count_w4), .busy(busy_w4)
  );

  always #5 rd_clk = ~rd_clk;

  always @(posedge rd_clk) cyc <= cyc + 1;

  // FIFO behaviour and scoreboard: each issued read is tagged with its cycle;
  // a word becomes visible two cycles later and leaves on an accepted beat.
  always @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      exp_q.delete();
      iss_q.delete();
      delivered <= 0;
    end else begin
      if (exp_q.size() > 0 && iss_q[0] <= cyc - 2 && out_ready) begin
        void'(exp_q.pop_front());
        void'(iss_q.pop_front());
        delivered <= delivered + 1;
      end
      if (rd_en) begin
        rd_data <= fifo_q[0];
        exp_q.push_back(fifo_q[0]);
        iss_q.push_back(cyc);
        void'(fifo_q.pop_front());
        issued <= issued + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_cycle();
    logic ev, er, ep;
    int   cnt;
    cnt = delivered;
    ev = (exp_q.size() > 0) && (iss_q[0] <= cyc - 2);
    ep = ev && out_ready;
    er = !rd_rst && drain_en && !rd_empty && ((exp_q.size() - int'(ep)) < 2);
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, ev});
    if (ev) check_eq("out_data", {24'd0, out_data}, {24'd0, exp_q[0]});
    check_eq("rd_en", {31'd0, rd_en}, {31'd0, er});
    check_eq("busy", {31'd0, busy}, {31'd0, (exp_q.size() > 0) || er});
    check_eq("out_count", {16'd0, out_count}, {16'd0, cnt[15:0]});
    check_eq("out_count_w4", {28'd0, out_count_w4}, {28'd0, cnt[3:0]});
    check_eq("rd_en_w4", {31'd0, rd_en_w4}, {31'd0, er});
  endtask

  task automatic step(input logic de, input logic ordy, input logic gap);
    @(negedge rd_clk);
    drain_en  = de;
    out_ready = ordy;
    rd_empty  = gap || (fifo_q.size() == 0);
    #1;
    check_cycle();
  endtask

  task automatic drain(input logic rnd, input int budget);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      if (rnd) step(1'b1, $urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0);
      else     step(1'b1, 1'b1, 1'b0);
      n++;
    end
    check_eq("drain_done", {31'd0, n < budget}, 32'd1);
    step(1'b1, 1'b1, 1'b0);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge rd_clk);
    rd_rst = 1'b1;
    @(negedge rd_clk);
    rd_rst = 1'b0;
  endtask

  initial begin
    int n0;
    rd_rst = 1'b1; drain_en = 1'b1; rd_empty = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge rd_clk);
    #1;
    check_eq("rst_rd_en", {31'd0, rd_en}, 32'd0);
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_data", {24'd0, out_data}, 32'd0);
    check_eq("rst_count", {16'd0, out_count}, 32'd0);
    rd_rst = 1'b0;

    // Preloaded burst at full throughput.
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
    drain(1'b0, 40);
    check_eq("burst_count", {16'd0, out_count}, 32'd3);

    // Backpressure: only two reads may be committed.
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'($urandom));
    n0 = issued;
    repeat (8) step(1'b1, 1'b0, 1'b0);
    check_eq("bp_reads", issued - n0, 32'd2);
    drain(1'b0, 40);

    // drain_en drops right after a read is issued.
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'($urandom));
    step(1'b1, 1'b1, 1'b0);
    check_eq("de_pulse", {31'd0, rd_en}, 32'd1);
    n0 = issued;
    repeat (6) step(1'b0, 1'b1, 1'b0);
    check_eq("de_reads", issued - n0, 32'd1);
    check_eq("de_flushed", exp_q.size(), 32'd0);
    drain(1'b0, 40);

    // Long random run with ready toggling and empty gaps.
    do_reset();
    for (int i = 0; i < 1000; i++) fifo_q.push_back(8'($urandom));
    drain(1'b1, 20000);
    check_eq("rand_count", {16'd0, out_count}, 32'd1000);
    check_eq("rand_count_w4", {28'd0, out_count_w4}, 32'd8);

    // Narrow counter wraps after 16 pops.
    do_reset();
    for (int i = 0; i < 17; i++) fifo_q.push_back(8'($urandom));
    drain(1'b0, 200);
    check_eq("wrap_w4", {28'd0, out_count_w4}, 32'd1);
    check_eq("wrap_w16", {16'd0, out_count}, 32'd17);

    // Asynchronous reset with a full buffer.
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'($urandom));
    repeat (5) step(1'b1, 1'b0, 1'b0);
    check_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rd_rst = 1'b1;
    #1;
    check_eq("arst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("arst_rd_en", {31'd0, rd_en}, 32'd0);
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_count", {16'd0, out_count}, 32'd0);
    repeat (2) step(1'b1, 1'b1, 1'b0);
    @(negedge rd_clk);
    rd_rst = 1'b0;
    drain(1'b0, 60);
    check_eq("post_rst_count", {16'd0, out_count}, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
